// File: rtl/tms_prog_loader.sv
// tms_prog_loader: Wishbone classic responder that loads and verifies the
// TMS1x00 program RAM, owns the core run/reset controls and the stage/error
// word presented on GPIO. The single-port program RAM belongs to Wishbone
// while the core is halted and to the core's instruction fetch while running.
module tms_prog_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          PM_AW     = 10
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    output logic             mem_en_o,
    output logic             mem_we_o,
    output logic [PM_AW-1:0] mem_addr_o,
    output logic [7:0]       mem_wdata_o,
    input  logic [7:0]       mem_rdata_i,
    input  logic [PM_AW-1:0] core_fetch_addr_i,
    output logic [7:0]       core_insn_o,
    output logic             core_run_o,
    output logic             core_reset_o,
    output logic [7:0]       stage_o,
    output logic             error_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MEM_RD = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    localparam logic [11:0] REG_CTRL   = 12'h000;
    localparam logic [11:0] REG_STATUS = 12'h004;
    localparam logic [11:0] REG_STAGE  = 12'h008;

    state_t      state_q, state_d;
    logic        ack_q, ack_d;
    logic [31:0] dat_q, dat_d;
    logic        run_q, run_d;
    logic        creset_q, creset_d;
    logic        conflict_q, conflict_d;
    logic [7:0]  stage_q, stage_d;
    logic        error_q, error_d;
    // RAM ownership follows run one cycle late, so a run change made by a
    // CTRL write only hands the RAM over once that write's ack has gone.
    logic        own_q, own_d;

    logic [31:0]      offset;
    logic             req;
    logic             is_mem;
    logic [11:0]      reg_off;
    logic [PM_AW-1:0] wb_addr;
    logic             wb_mem_en;
    logic             wb_mem_we;
    logic             conflict_set;
    logic             conflict_clr;

    // Address decode. Requests are masked while reset is asserted so that no
    // RAM write can be launched combinationally during reset.
    assign offset  = wbs_adr_i - BASE_ADDR;
    assign req     = wbs_cyc_i & wbs_stb_i & (offset < 32'h0000_2000) & ~wb_rst_i;
    assign is_mem  = ~offset[12];
    assign reg_off = offset[11:0];
    assign wb_addr = offset[PM_AW+1:2];

    // Bus FSM next state, register updates and the Wishbone side of the RAM.
    always_comb begin
        state_d      = state_q;
        dat_d        = dat_q;
        run_d        = run_q;
        creset_d     = creset_q;
        stage_d      = stage_q;
        error_d      = error_q;
        own_d        = run_q;
        wb_mem_en    = 1'b0;
        wb_mem_we    = 1'b0;
        conflict_set = 1'b0;
        conflict_clr = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_ACK;
                    dat_d   = 32'h0;
                    if (is_mem) begin
                        if (run_q) begin
                            // Core owns the RAM: drop the access, flag it.
                            conflict_set = 1'b1;
                        end else if (wbs_we_i) begin
                            // Data lives in byte lane 0 only.
                            wb_mem_en = wbs_sel_i[0];
                            wb_mem_we = wbs_sel_i[0];
                        end else begin
                            wb_mem_en = 1'b1;
                            state_d   = ST_MEM_RD;
                        end
                    end else if (wbs_we_i) begin
                        case (reg_off)
                            REG_CTRL: begin
                                if (wbs_sel_i[0]) begin
                                    run_d    = wbs_dat_i[0];
                                    creset_d = wbs_dat_i[1];
                                end
                            end
                            REG_STATUS: begin
                                conflict_clr = wbs_sel_i[0] & wbs_dat_i[1];
                            end
                            REG_STAGE: begin
                                if (wbs_sel_i[0]) begin
                                    stage_d = wbs_dat_i[7:0];
                                end
                                if (wbs_sel_i[1]) begin
                                    error_d = wbs_dat_i[8];
                                end
                            end
                            default: begin
                            end
                        endcase
                    end else begin
                        case (reg_off)
                            REG_CTRL:   dat_d = {30'h0, creset_q, run_q};
                            REG_STATUS: dat_d = {30'h0, conflict_q, run_q};
                            REG_STAGE:  dat_d = {23'h0, error_q, stage_q};
                            default:    dat_d = 32'h0;
                        endcase
                    end
                end
            end
            ST_MEM_RD: begin
                dat_d   = {24'h0, mem_rdata_i};
                state_d = ST_ACK;
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A clear and a fresh conflict in the same cycle leave the flag set.
        conflict_d = (conflict_q & ~conflict_clr) | conflict_set;
        ack_d      = (state_d == ST_ACK);
    end

    // State and register flops; reset abandons any in-flight transaction.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q    <= ST_IDLE;
            ack_q      <= 1'b0;
            dat_q      <= 32'h0;
            run_q      <= 1'b0;
            creset_q   <= 1'b0;
            conflict_q <= 1'b0;
            stage_q    <= 8'hFF;
            error_q    <= 1'b0;
            own_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ack_q      <= ack_d;
            dat_q      <= dat_d;
            run_q      <= run_d;
            creset_q   <= creset_d;
            conflict_q <= conflict_d;
            stage_q    <= stage_d;
            error_q    <= error_d;
            own_q      <= own_d;
        end
    end

    // RAM port mux: the core fetches continuously while it owns the RAM.
    assign mem_en_o    = own_q | wb_mem_en;
    assign mem_we_o    = ~own_q & wb_mem_we;
    assign mem_addr_o  = own_q ? core_fetch_addr_i : wb_addr;
    assign mem_wdata_o = wbs_dat_i[7:0];

    assign core_insn_o  = mem_rdata_i;
    assign core_run_o   = run_q;
    assign core_reset_o = creset_q;
    assign stage_o      = stage_q;
    assign error_o      = error_q;
    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;

    logic unused_inputs;
    assign unused_inputs = ^{wbs_sel_i[3:2], wbs_dat_i[31:9]};

endmodule

// File: tb/tb_tms_prog_loader.sv
// Bench for tms_prog_loader: a driver issues Wishbone transactions and pushes
// the reference model's predicted response into a queue; a monitor pops and
// compares on every ack. A behavioural RAM sits on the program-memory port.
module tb_tms_prog_loader;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        cyc, stb, we;
    logic [3:0]  sel;
    logic [31:0] adr, wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic [9:0]  fetch;
    logic [7:0]  insn;
    logic        run_o, creset_o;
    logic [7:0]  stage;
    logic        err;

    always #5 clk = ~clk;

    tms_prog_loader #(.BASE_ADDR(BASE), .PM_AW(10)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack), .wbs_dat_o(rdat),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
        .core_fetch_addr_i(fetch), .core_insn_o(insn),
        .core_run_o(run_o), .core_reset_o(creset_o),
        .stage_o(stage), .error_o(err)
    );

    // Program RAM with registered read data.
    logic [7:0] ram [0:1023];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            mem_rdata <= ram[mem_addr];
        end
    end

    int checks = 0;
    int failures = 0;
    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt++;

    typedef struct {
        logic [31:0] dat;
        bit          chk;
        int          lat;
        int          issue;
    } exp_t;
    exp_t sb[$];

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endfunction

    // Reference model: behaviour expressed directly from the address map.
    logic [7:0] mmem [0:1023];
    bit         m_run, m_crst, m_conf, m_err;
    logic [7:0] m_stage;

    task automatic model_reset();
        m_run = 0; m_crst = 0; m_conf = 0; m_err = 0; m_stage = 8'hFF;
    endtask

    task automatic model_apply(input logic [31:0] off, input bit w, input logic [3:0] s,
                               input logic [31:0] d, output logic [31:0] e,
                               output bit c, output int l);
        e = 32'h0; c = !w; l = 1;
        if (off < 32'h1000) begin
            if (m_run) m_conf = 1;
            else if (w) begin
                if (s[0]) mmem[off[11:2]] = d[7:0];
            end else begin
                e = {24'h0, mmem[off[11:2]]};
                l = 2;
            end
        end else begin
            case (off[11:0])
                12'h000: if (w) begin
                             if (s[0]) begin m_run = d[0]; m_crst = d[1]; end
                         end else e = {30'h0, m_crst, m_run};
                12'h004: if (w) begin
                             if (s[0] && d[1]) m_conf = 0;
                         end else e = {30'h0, m_conf, m_run};
                12'h008: if (w) begin
                             if (s[0]) m_stage = d[7:0];
                             if (s[1]) m_err = d[8];
                         end else e = {23'h0, m_err, m_stage};
                default: ;
            endcase
        end
    endtask

    // Monitor: every ack must match the oldest outstanding prediction.
    always @(negedge clk) begin
        if (ack === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", {31'h0, ack}, 32'h0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("ack_latency", cyc_cnt - e.issue, e.lat);
                if (e.chk) chk("rdata", rdat, e.dat);
            end
        end
    end

    task automatic xfer(input logic [31:0] off, input bit w, input logic [3:0] s,
                        input logic [31:0] d, input bit cm, input bit xen,
                        input bit xwe, input logic [9:0] xaddr);
        exp_t        e;
        logic [31:0] ed;
        bit          ec;
        int          el;
        bit          got;
        model_apply(off, w, s, d, ed, ec, el);
        e.dat = ed; e.chk = ec; e.lat = el;
        @(posedge clk); #1;
        adr = BASE + off; we = w; sel = s; wdat = d; cyc = 1; stb = 1;
        e.issue = cyc_cnt;
        sb.push_back(e);
        got = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0 && cm) begin
                chk("mem_en", {31'h0, mem_en}, {31'h0, xen});
                chk("mem_we", {31'h0, mem_we}, {31'h0, xwe});
                chk("mem_addr", {22'h0, mem_addr}, {22'h0, xaddr});
            end
            if (ack) begin got = 1; break; end
        end
        if (!got) begin
            chk("ack_timeout", {31'h0, got}, 32'h1);
            if (sb.size() > 0) sb.delete(0);
        end
        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic rd(input logic [31:0] off);
        xfer(off, 0, 4'hF, 32'h0, 0, 0, 0, 10'h0);
    endtask

    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        xfer(off, 1, 4'hF, d, 0, 0, 0, 10'h0);
    endtask

    task automatic out_chk();
        chk("stage_o", {24'h0, stage}, {24'h0, m_stage});
        chk("error_o", {31'h0, err}, {31'h0, m_err});
        chk("core_run_o", {31'h0, run_o}, {31'h0, m_run});
        chk("core_reset_o", {31'h0, creset_o}, {31'h0, m_crst});
    endtask

    task automatic no_ack(input logic [31:0] a);
        int seen;
        @(posedge clk); #1;
        adr = a; we = 0; sel = 4'hF; cyc = 1; stb = 1;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (ack) seen++;
        end
        chk("no_ack", seen, 0);
        @(posedge clk); #1;
        cyc = 0; stb = 0;
    endtask

    initial begin
        int seen;
        rst = 1; cyc = 0; stb = 0; we = 0; sel = 4'h0; adr = 32'h0; wdat = 32'h0;
        fetch = 10'h0;
        for (int i = 0; i < 1024; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            ram[i] = b;
            mmem[i] = b;
        end
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", {31'h0, ack}, 32'h0);
        chk("rst_dat", rdat, 32'h0);
        out_chk();
        @(posedge clk); #1;
        rst = 0;

        // Reset-state readback.
        rd(32'h1008);
        rd(32'h1000);
        out_chk();

        // Program memory write/readback at both ends of the map.
        xfer(32'h0004, 1, 4'hF, 32'h0000_00A5, 1, 1, 1, 10'd1);
        xfer(32'h0FFC, 1, 4'hF, 32'h0000_003C, 1, 1, 1, 10'd1023);
        xfer(32'h0004, 0, 4'hF, 32'h0, 1, 1, 0, 10'd1);
        xfer(32'h0FFC, 0, 4'hF, 32'h0, 1, 1, 0, 10'd1023);

        // Byte lane 0 disabled: no RAM write.
        xfer(32'h0008, 1, 4'b1110, 32'h0000_00FF, 1, 0, 0, 10'd2);
        rd(32'h0008);

        // Run mode: core fetches, Wishbone memory access is a conflict.
        fetch = 10'd5;
        wr(32'h1000, 32'h1);
        repeat (2) @(negedge clk);
        chk("fetch_addr", {22'h0, mem_addr}, 32'd5);
        chk("insn", {24'h0, insn}, {24'h0, mmem[5]});
        xfer(32'h0014, 1, 4'hF, $urandom, 1, 1, 0, 10'd5);
        rd(32'h1004);
        wr(32'h1004, 32'h2);
        rd(32'h1004);
        rd(32'h0010);
        wr(32'h1000, 32'h2);
        out_chk();
        wr(32'h1000, 32'h0);
        rd(32'h0014);
        out_chk();

        // Stage/error word and unmapped addresses.
        wr(32'h1008, 32'h0000_0102);
        out_chk();
        rd(32'h1008);
        no_ack(BASE + 32'h2000);
        no_ack(BASE - 32'h4);

        // Reset asserted while the read sits in MEM_RD.
        @(posedge clk); #1;
        adr = BASE + 32'h4; we = 0; sel = 4'hF; cyc = 1; stb = 1;
        @(posedge clk); #1;
        rst = 1; cyc = 0; stb = 0;
        model_reset();
        @(negedge clk);
        chk("rst_mid_ack", {31'h0, ack}, 32'h0);
        out_chk();
        @(posedge clk); #1;
        rst = 0;
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (ack) seen++;
        end
        chk("rst_mid_no_ack", seen, 0);
        rd(32'h0004);

        // Randomised traffic against the model.
        for (int n = 0; n < 300; n++) begin
            int          kind;
            logic [31:0] off, d;
            bit          w;
            logic [3:0]  s;
            kind = $urandom_range(0, 9);
            w = 1'($urandom);
            s = 4'($urandom);
            d = $urandom;
            fetch = 10'($urandom);
            case (kind)
                0, 1, 2, 3, 4, 5: off = $urandom_range(0, 32'hFFF);
                6: begin
                    off = 32'h1000;
                    d = (d & ~32'h1) | {31'h0, ($urandom_range(0, 3) == 0)};
                end
                7: off = 32'h1004;
                8: off = 32'h1008;
                default: off = 32'h1000 + $urandom_range(0, 32'hFFF);
            endcase
            xfer(off, w, s, d, 0, 0, 0, 10'h0);
            if (n % 16 == 15) out_chk();
        end

        // Leave run off and verify a few words end-to-end.
        wr(32'h1000, 32'h0);
        for (int n = 0; n < 8; n++) rd({20'h0, 10'($urandom), 2'b00});

        repeat (5) @(posedge clk);
        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
